div_iter: RTL

//   Iterative radix-2 restoring divider executing RV32M DIV/DIVU/REM/REMU.

---
 rtl/div_pkg.sv | 24 ++
 rtl/div_step.sv | 28 ++
 rtl/div_iter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared op encodings, FSM state codes and width default for div_iter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int DIV_XLEN = 32;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module   : div_step
// Purpose  : One combinational restoring-division iteration (shift, trial subtract).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            dvd_msb,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_nxt,
  output logic            q_bit
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_trial;

  assign w_shift = {rem, dvd_msb};
  assign w_trial = w_shift - {1'b0, dvs};
  assign q_bit   = ~w_trial[XLEN];
  assign rem_nxt = q_bit ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];

endmodule

`default_nettype wire

// File: rtl/div_iter.sv
// ============================================================================
// Module   : div_iter
// Purpose  : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//            Optional macro DIV_EARLY_OUT_EN: finish at accept when |a| < |b|.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module div_iter
  import div_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_dvd;
  logic [XLEN-1:0] r_dvs;
  logic [XLEN-1:0] r_result;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_sel_rem;

  logic            w_accept;
  logic            w_signed;
  logic            w_div0;
  logic            w_ovf;
  logic            w_early;
  logic            w_special;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic [XLEN-1:0] w_special_res;
  logic [XLEN-1:0] w_rem_nxt;
  logic            w_q_bit;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_signed = ~op[0];
  assign w_mag_a  = (w_signed && a[XLEN-1]) ? -a : a;
  assign w_mag_b  = (w_signed && b[XLEN-1]) ? -b : b;

  // Cases resolved without iterating: divide by zero and the one signed overflow.
  assign w_div0 = (b == '0);
  assign w_ovf  = w_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
`ifdef DIV_EARLY_OUT_EN
  assign w_early = (w_mag_a < w_mag_b);
`else
  assign w_early = 1'b0;
`endif
  assign w_special = w_div0 || w_ovf || w_early;

  always_comb begin
    w_special_res = '0;
    if (op[1]) begin
      if (!w_ovf) w_special_res = a;
    end else begin
      if (w_div0)     w_special_res = '1;
      else if (w_ovf) w_special_res = a;
    end
  end

  div_step #(.XLEN(XLEN)) u_step (
    .rem     (r_rem),
    .dvd_msb (r_dvd[XLEN-1]),
    .dvs     (r_dvs),
    .rem_nxt (w_rem_nxt),
    .q_bit   (w_q_bit)
  );

  assign w_q_fix = r_neg_q ? -r_dvd : r_dvd;
  assign w_r_fix = r_neg_r ? -r_rem : r_rem;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
      S_CALC:  if (r_cnt == CNT_W'(XLEN-1)) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Quotient bits shift into the dividend register as its MSBs are consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_result  <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_sel_rem <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dvd     <= w_mag_a;
            r_dvs     <= w_mag_b;
            r_neg_q   <= w_signed && (a[XLEN-1] ^ b[XLEN-1]);
            r_neg_r   <= w_signed && a[XLEN-1];
            r_sel_rem <= op[1];
            r_rem     <= '0;
            r_cnt     <= '0;
            if (w_special) r_result <= w_special_res;
          end
        end
        S_CALC: begin
          r_rem <= w_rem_nxt;
          r_dvd <= {r_dvd[XLEN-2:0], w_q_bit};
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: r_result <= r_sel_rem ? w_r_fix : w_q_fix;
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign result    = r_result;

endmodule

`default_nettype wire
